// File: rtl/imem_arb.sv
// imem_arb: arbitrates an instruction-fetch port and a load/store port onto
// one single-port TCM. One access per cycle, grants are combinational, read
// data comes back one cycle after the grant and is steered to the owner.
// Default build uses strict data priority. Defining IMEM_ARB_FAIR_EN adds a
// fetch-wait counter that forces a fetch grant after STARVE_MAX lost cycles.
module imem_arb #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    // Instruction fetch port (read-only)
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    // Load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    // Single-port TCM
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    // Debug/trace
    output logic [3:0]    starve_cnt
);

    // Owner of the TCM access issued in the previous cycle.
    localparam logic [1:0] OWN_IDLE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;

`ifdef IMEM_ARB_FAIR_EN
    localparam logic FAIR_EN = 1'b1;
`else
    localparam logic FAIR_EN = 1'b0;
`endif

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STARVE_SAT = 4'hF;

    logic [1:0] r_owner;
    logic       r_d_read;   // the data access just granted was a read
    logic [3:0] r_starve;

    logic       w_run;      // out of reset: grants and rvalids allowed
    logic       w_f_force;  // fetch has waited long enough to beat data
    logic       w_f_gnt;
    logic       w_d_gnt;

    assign w_run     = reset;
    assign w_f_force = FAIR_EN & f_req & (r_starve >= STARVE_LIM);

    // Data wins unless fetch is being forced; fetch takes whatever is left.
    assign w_d_gnt = w_run & d_req & ~w_f_force;
    assign w_f_gnt = w_run & f_req & ~w_d_gnt;

    assign f_gnt = w_f_gnt;
    assign d_gnt = w_d_gnt;

    // TCM command mux: data port drives everything when granted, otherwise
    // the fetch address is presented as a plain full-word read.
    assign m_en    = w_f_gnt | w_d_gnt;
    assign m_we    = w_d_gnt & d_we;
    assign m_be    = w_d_gnt ? d_be    : 4'hF;
    assign m_addr  = w_d_gnt ? d_addr  : f_addr;
    assign m_wdata = w_d_gnt ? d_wdata : 32'd0;

    // Return path: rvalid follows the registered owner, data is not registered.
    // Gating with w_run drops the response of an access granted just before reset.
    assign f_rvalid = w_run & (r_owner == OWN_FETCH);
    assign d_rvalid = w_run & (r_owner == OWN_DATA) & r_d_read;
    assign f_rdata  = f_rvalid ? m_rdata : 32'd0;
    assign d_rdata  = d_rvalid ? m_rdata : 32'd0;

    assign starve_cnt = r_starve;

    // Record who owns the TCM read data arriving next cycle.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and kept out of the sensitivity list.
        if (!reset) begin
            r_owner  <= OWN_IDLE;
            r_d_read <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            r_d_read <= w_d_gnt & ~d_we;
            if (w_d_gnt) begin
                r_owner <= OWN_DATA;
            end else if (w_f_gnt) begin
                r_owner <= OWN_FETCH;
            end else begin
                r_owner <= OWN_IDLE;
            end
        end
    end

    // Count consecutive cycles a fetch request loses; stays 0 without fairness.
    always_ff @(posedge clk) begin
        if (!reset || !FAIR_EN || w_f_gnt) begin
            r_starve <= 4'd0;
        end else if (f_req && (r_starve != STARVE_SAT)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: directed scenarios plus randomized traffic for imem_arb, checked
// every cycle against a transaction-level model of the arbiter and the TCM.
// Honours IMEM_ARB_FAIR_EN the same way the design does.
module tb_imem_arb;

    localparam int AW    = 14;
    localparam int SMAX  = 4;
    localparam int MWORDS = 1024;

`ifdef IMEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [31:0]   f_rdata;
    logic          d_req, d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          m_en, m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic [3:0]    starve_cnt;

    int n_checks = 0;
    int n_errors = 0;

    imem_arb #(.AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    // TCM driven by the DUT's memory port; one-cycle read latency.
    logic [31:0] tcm [0:MWORDS-1];
    logic [31:0] tcm_q = 32'd0;
    assign m_rdata = tcm_q;

    always @(posedge clk) begin
        logic [31:0] merged;
        if (m_en) begin
            if (m_we) begin
                merged = tcm[m_addr[9:0]];
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) merged[8*b +: 8] = m_wdata[8*b +: 8];
                tcm[m_addr[9:0]] <= merged;
            end else begin
                tcm_q <= tcm[m_addr[9:0]];
            end
        end
    end

    // Reference model: memory image, last-cycle transaction, fetch wait count.
    typedef enum int { T_NONE, T_FETCH, T_DREAD, T_DWRITE } txn_e;
    logic [31:0] ref_mem [0:MWORDS-1];
    txn_e        prev_txn  = T_NONE;
    logic [31:0] prev_data = 32'd0;
    int          ref_starve = 0;
    bit          last_f_gnt, last_d_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for the falling edge, compare every output with the model, then
    // advance the model by this cycle's transaction.
    task automatic step();
        bit          e_fgnt, e_dgnt, e_frv, e_drv, forced;
        logic [31:0] w;
        @(negedge clk);
        forced = FAIR && f_req && (ref_starve >= SMAX);
        e_dgnt = reset && d_req && !forced;
        e_fgnt = reset && f_req && !e_dgnt;
        e_frv  = reset && (prev_txn == T_FETCH);
        e_drv  = reset && (prev_txn == T_DREAD);

        check("f_gnt",      32'(f_gnt),      32'(e_fgnt));
        check("d_gnt",      32'(d_gnt),      32'(e_dgnt));
        check("m_en",       32'(m_en),       32'(e_fgnt | e_dgnt));
        check("m_we",       32'(m_we),       32'(e_dgnt && d_we));
        check("m_be",       32'(m_be),       e_dgnt ? 32'(d_be) : 32'hF);
        check("m_addr",     32'(m_addr),     e_dgnt ? 32'(d_addr) : 32'(f_addr));
        check("m_wdata",    m_wdata,         e_dgnt ? d_wdata : 32'd0);
        check("f_rvalid",   32'(f_rvalid),   32'(e_frv));
        check("f_rdata",    f_rdata,         e_frv ? prev_data : 32'd0);
        check("d_rvalid",   32'(d_rvalid),   32'(e_drv));
        check("d_rdata",    d_rdata,         e_drv ? prev_data : 32'd0);
        check("starve_cnt", 32'(starve_cnt), 32'(ref_starve));

        if (!reset) begin
            prev_txn   = T_NONE;
            ref_starve = 0;
        end else begin
            if (e_dgnt && d_we) begin
                w = ref_mem[d_addr[9:0]];
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                ref_mem[d_addr[9:0]] = w;
                prev_txn = T_DWRITE;
            end else if (e_dgnt) begin
                prev_txn  = T_DREAD;
                prev_data = ref_mem[d_addr[9:0]];
            end else if (e_fgnt) begin
                prev_txn  = T_FETCH;
                prev_data = ref_mem[f_addr[9:0]];
            end else begin
                prev_txn = T_NONE;
            end
            if (!FAIR || e_fgnt)  ref_starve = 0;
            else if (f_req)       ref_starve = (ref_starve < 15) ? ref_starve + 1 : 15;
        end
        last_f_gnt = e_fgnt;
        last_d_gnt = e_dgnt;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pf, pd;
        int exp_s [6] = '{0, 1, 2, 3, 4, 0};

        for (int i = 0; i < MWORDS; i++) begin
            tcm[i]     = {16'hC0DE, 16'(i)};
            ref_mem[i] = {16'hC0DE, 16'(i)};
        end
        tcm[16'h010]     = 32'h0000_0013;
        ref_mem[16'h010] = 32'h0000_0013;

        reset = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        d_be = 4'h0; f_addr = '0; d_addr = '0; d_wdata = 32'd0;
        advance();

        // Reset blocks every grant even with both ports requesting.
        f_req = 1'b1; d_req = 1'b1;
        step();
        check("lit_rst_f_gnt", 32'(f_gnt), 32'd0);
        check("lit_rst_d_gnt", 32'(d_gnt), 32'd0);
        check("lit_rst_m_en",  32'(m_en),  32'd0);
        advance();
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0;
        step();
        check("lit_idle_f_rvalid",   32'(f_rvalid),   32'd0);
        check("lit_idle_starve_cnt", 32'(starve_cnt), 32'd0);
        advance();

        // Single fetch, data one cycle later, then quiet.
        f_req = 1'b1; f_addr = 14'h010;
        step();
        check("lit_fetch_gnt",  32'(f_gnt),  32'd1);
        check("lit_fetch_addr", 32'(m_addr), 32'h010);
        advance();
        f_req = 1'b0;
        step();
        check("lit_fetch_rvalid", 32'(f_rvalid), 32'd1);
        check("lit_fetch_rdata",  f_rdata,       32'h0000_0013);
        advance();
        step();
        check("lit_fetch_rvalid_drop", 32'(f_rvalid), 32'd0);
        check("lit_fetch_rdata_drop",  f_rdata,       32'd0);
        advance();

        // Simultaneous requests: data first, fetch stays pending.
        f_req = 1'b1; f_addr = 14'h011;
        d_req = 1'b1; d_we = 1'b0; d_addr = 14'h020; d_be = 4'hF;
        step();
        check("lit_both_d_gnt", 32'(d_gnt), 32'd1);
        check("lit_both_f_gnt", 32'(f_gnt), 32'd0);
        advance();
        d_req = 1'b0;
        step();
        check("lit_both_d_rvalid", 32'(d_rvalid), 32'd1);
        check("lit_both_d_rdata",  d_rdata,       32'hC0DE_0020);
        check("lit_both_f_late",   32'(f_gnt),    32'd1);
        advance();
        f_req = 1'b0;
        step();
        check("lit_both_f_rdata", f_rdata, 32'hC0DE_0011);
        advance();

        // Partial write then read-back of the merged word.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 14'h030; d_wdata = 32'hDEAD_BEEF;
        step();
        check("lit_wr_m_we",    32'(m_we),  32'd1);
        check("lit_wr_m_be",    32'(m_be),  32'h3);
        check("lit_wr_m_wdata", m_wdata,    32'hDEAD_BEEF);
        advance();
        d_we = 1'b0; d_be = 4'hF;
        step();
        check("lit_wr_no_rvalid", 32'(d_rvalid), 32'd0);
        advance();
        d_req = 1'b0;
        step();
        check("lit_rd_rvalid", 32'(d_rvalid), 32'd1);
        check("lit_rd_rdata",  d_rdata,       32'hC0DE_BEEF);
        advance();

        // Data held high against a waiting fetch for ten cycles.
        d_req = 1'b1; d_addr = 14'h020; f_req = 1'b1; f_addr = 14'h012;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (FAIR) begin
                if (i <= 6) begin
                    check("lit_fair_starve", 32'(starve_cnt), 32'(exp_s[i-1]));
                    check("lit_fair_f_gnt",  32'(f_gnt),      32'(i == 5));
                end
            end else begin
                check("lit_nofair_f_gnt",  32'(f_gnt),      32'd0);
                check("lit_nofair_starve", 32'(starve_cnt), 32'd0);
            end
            advance();
        end
        d_req = 1'b0; f_req = 1'b0;
        step(); advance();
        step(); advance();

        // Reset right after a fetch grant swallows its response.
        f_req = 1'b1; f_addr = 14'h010;
        step();
        check("lit_rst_fetch_gnt", 32'(f_gnt), 32'd1);
        advance();
        reset = 1'b0; d_req = 1'b1;
        step();
        check("lit_rst_no_rvalid", 32'(f_rvalid), 32'd0);
        check("lit_rst_no_fgnt",   32'(f_gnt),    32'd0);
        check("lit_rst_no_dgnt",   32'(d_gnt),    32'd0);
        advance();
        step(); advance();
        reset = 1'b1; d_req = 1'b0;
        step();
        check("lit_post_rst_gnt",    32'(f_gnt),    32'd1);
        check("lit_post_rst_rvalid", 32'(f_rvalid), 32'd0);
        advance();
        f_req = 1'b0;
        step(); advance();

        // Random traffic: requesters hold until granted, occasional reset.
        pf = 1'b0; pd = 1'b0;
        repeat (3000) begin
            if (!pf && ($urandom_range(0, 2) != 0)) begin
                pf = 1'b1;
                f_addr = AW'($urandom_range(0, 63));
            end
            if (!pd && ($urandom_range(0, 1) != 0)) begin
                pd = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(0, 15));
                d_addr  = AW'($urandom_range(0, 63));
                d_wdata = $urandom;
            end
            f_req = pf; d_req = pd;
            reset = ($urandom_range(0, 199) != 0);
            step();
            if (last_f_gnt) pf = 1'b0;
            if (last_d_gnt) pd = 1'b0;
            advance();
        end
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0;
        step(); advance();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
Parameters:
REQ-001 SHALL have parameter AW, default 14: word-address width of the shared TCM.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive fetch-wait cycles that force a fetch grant (4-bit counter, legal 1..15).
Ports:
REQ-003 SHALL have clk  input  1  clock; all state updates on posedge.
REQ-004 SHALL have reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have f_req  input  1; f_addr  input  AW; f_gnt  output  1; f_rvalid  output  1; f_rdata  output  32  (instruction fetch port, read-only).
REQ-006 SHALL have d_req  input  1; d_we  input  1; d_be  input  4; d_addr  input  AW; d_wdata  input  32; d_gnt  output  1; d_rvalid  output  1; d_rdata  output  32  (load/store port).
REQ-007 SHALL have m_en  output  1; m_we  output  1; m_be  output  4; m_addr  output  AW; m_wdata  output  32; m_rdata  input  32  (single-port TCM, read data valid 1 cycle after m_en).
REQ-008 SHALL have starve_cnt  output  4  current fetch-wait count (debug/trace).

Function
REQ-009 SHALL issue at most one TCM access per cycle; m_en = f_gnt | d_gnt.
REQ-010 SHALL generate grants combinationally in the cycle of the request; a requester holds req/addr/data stable until it sees gnt.
REQ-011 SHALL, without fairness, grant d when d_req=1, else grant f when f_req=1 (data priority).
REQ-012 SHALL drive m_we/m_be/m_addr/m_wdata from d when d_gnt=1, else m_addr=f_addr, m_we=0, m_be=4'hF, m_wdata=0.
REQ-013 SHALL keep a registered owner state: IDLE (no access last cycle), FETCH (f granted last cycle), DATA (d granted last cycle); next state from this cycle's grant.
REQ-014 SHALL assert f_rvalid for exactly one cycle when owner=FETCH, and d_rvalid one cycle when owner=DATA and the granted access was a read (d_we=0, registered).
REQ-015 SHALL route m_rdata to f_rdata/d_rdata unregistered; outputs are 0 when the corresponding rvalid is 0.
REQ-016 SHALL generate no rvalid for a write; a write grant still sets owner=DATA.
REQ-017 SHALL support back-to-back grants every cycle with the same or different requesters (throughput 1 access/cycle).
REQ-018 SHALL accept f_req and d_req both high in the same cycle and grant exactly one per REQ-011/REQ-020; the loser stays pending.

Reset
REQ-019 SHALL, while reset=0 at posedge, set owner=IDLE, starve_cnt=0; during reset f_gnt, d_gnt, m_en, f_rvalid, d_rvalid SHALL be 0 regardless of requests; an access granted in the cycle before reset asserts produces no rvalid.

Configuration
REQ-020 SHALL, when macro IMEM_ARB_FAIR_EN is defined, increment starve_cnt each cycle f_req=1 and f_gnt=0 (saturating at 15), clear it on f_gnt, and grant f over d when starve_cnt >= STARVE_MAX.
REQ-021 SHALL, when IMEM_ARB_FAIR_EN is undefined, hold starve_cnt at 0 and use pure data priority (fetch may starve indefinitely).

Verification
REQ-022 SHALL verify: f_req only, f_addr=0x010, m_rdata=0x00000013 next cycle -> f_gnt same cycle, f_rvalid=1 with f_rdata=0x00000013 one cycle later, then 0.
REQ-023 SHALL verify: f_req and d_req (read, addr 0x020) together one cycle -> d_gnt=1, f_gnt=0, d_rvalid next cycle; f granted the following cycle when d_req drops.
REQ-024 SHALL verify: d write addr 0x030, data 0xDEADBEEF, be=4'b0011 -> m_we=1, m_be=4'b0011, m_wdata=0xDEADBEEF, no d_rvalid next cycle; following read of 0x030 returns memory model data.
REQ-025 SHALL verify with IMEM_ARB_FAIR_EN, STARVE_MAX=4: d_req held high and f_req high for 10 cycles -> f_gnt in cycle 5, starve_cnt sequence 0,1,2,3,4,0; without macro -> f_gnt never asserted, starve_cnt=0.
REQ-026 SHALL verify: reset=0 asserted in the cycle after a fetch grant -> no f_rvalid, owner=IDLE, all grants 0 while reset=0, normal grant in first cycle after reset=1.
